// File: rtl/serial_seq_tx_pkg.sv
// Shared definitions for the serial sequence transmitter.
// State encodings match the ones used by the sequence detector so that
// both ends of the sseq path decode the same values.
package serial_seq_tx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Even parity over a pattern (zero-extended to 64 bits; padding zeros do not change it)
    function automatic logic calc_parity(input logic [63:0] i_vec);
        return ^i_vec;
    endfunction

endpackage

// File: rtl/serial_seq_tx_seq_bit_counter.sv
// seq_bit_counter: loadable down-counter with synchronous active-high reset
// and a zero flag. Decrement saturates at zero so the count never wraps.
module seq_bit_counter #(
    parameter int CW = 3
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    // Count register: reset clears, load has priority over decrement
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_count <= {CW{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CW{1'b0}})) begin
            r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == {CW{1'b0}});

endmodule

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: shifts a WIDTH-bit pattern out MSB-first on Dout with a
// bit-valid strobe and a last-bit flag. All outputs are registered.
// Optional feature macro: SEQ_TX_PARITY_EN appends one even-parity bit per
// frame (Last then marks the parity bit instead of the LSB).
// Dout shows the current bit; r_shreg holds the bits still to be sent,
// and the counter holds how many of them remain (WIDTH <= 64).
module serial_seq_tx
    import serial_seq_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    output logic             Ready,
    output logic             Dout,
    output logic             Valid,
    output logic             Last
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_dout;
    logic             r_valid;
    logic             r_last;
    logic             r_ready;
`ifdef SEQ_TX_PARITY_EN
    logic             r_parity;
`endif

    logic             w_accept;
    logic             w_dec;
    logic [CW-1:0]    w_count;
    logic             w_zero;

    // Handshake and counter control
    always_comb begin
        w_accept = Start && r_ready;
        if (!w_accept && (r_state == ST_SHIFT) && !w_zero) begin
            w_dec = 1'b1;
        end else begin
            w_dec = 1'b0;
        end
    end

    seq_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .CLK        (CLK),
        .Reset      (Reset),
        .i_load     (w_accept),
        .i_load_val (CW'(WIDTH - 1)),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

`ifdef SEQ_TX_PARITY_EN
    // Parity of the frame, captured on the accepting edge
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= calc_parity(64'(Pattern));
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    // FSM, shift register and registered serial outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_dout  <= IDLE_LEVEL;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
        end else if (w_accept) begin
            // New frame (from IDLE or back-to-back in the Last cycle)
            r_state <= ST_SHIFT;
            r_shreg <= {Pattern[WIDTH-2:0], 1'b0};
            r_dout  <= Pattern[WIDTH-1];
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (!w_zero) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_dout  <= r_shreg[WIDTH-1];
                        r_valid <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
                        r_last  <= 1'b0;
                        r_ready <= 1'b0;
`else
                        r_last  <= (w_count == CW'(1));
                        r_ready <= (w_count == CW'(1));
`endif
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        r_state <= ST_PARITY;
                        r_shreg <= r_shreg;
                        r_dout  <= r_parity;
                        r_valid <= 1'b1;
                        r_last  <= 1'b1;
                        r_ready <= 1'b1;
`else
                        r_state <= ST_IDLE;
                        r_shreg <= r_shreg;
                        r_dout  <= IDLE_LEVEL;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_ready <= 1'b1;
`endif
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_IDLE;
                    r_shreg <= r_shreg;
                    r_dout  <= IDLE_LEVEL;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_shreg <= r_shreg;
                    r_dout  <= IDLE_LEVEL;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign Ready = r_ready;
    assign Dout  = r_dout;
    assign Valid = r_valid;
    assign Last  = r_last;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Scoreboard bench for serial_seq_tx (WIDTH=8). Expected bits are queued when
// a Start is issued; a negedge monitor pops and compares every valid bit and
// checks the idle level on every non-valid cycle.
module tb_serial_seq_tx;

    localparam int   WIDTH      = 8;
    localparam logic IDLE_LEVEL = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam int FL = WIDTH + (PAR ? 1 : 0);

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] Pattern;
    logic             Ready;
    logic             Dout;
    logic             Valid;
    logic             Last;

    int total = 0;
    int bad   = 0;
    int run_len = 0;
    int max_run = 0;
    int last_cnt = 0;

    // entry = {dout, last, ready}
    logic [2:0] exp_q[$];

    serial_seq_tx #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Pattern (Pattern),
        .Ready   (Ready),
        .Dout    (Dout),
        .Valid   (Valid),
        .Last    (Last)
    );

    // Clock: first posedge at 5, negedges at 10, 20, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Monitor: compares outputs against the scoreboard away from the clock edge
    always @(negedge CLK) begin
        logic [2:0] e;
        if (Valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (Last === 1'b1) last_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bit: got Dout=%0b Last=%0b Ready=%0b, required no valid bit",
                         Dout, Last, Ready);
            end else begin
                e = exp_q.pop_front();
                if ({Dout, Last, Ready} !== e) begin
                    bad++;
                    $display("FAIL bit_compare: got {Dout,Last,Ready}=%b, required %b", {Dout, Last, Ready}, e);
                end
            end
        end else begin
            run_len = 0;
            total++;
            if ({Valid, Dout, Last, Ready} !== {1'b0, IDLE_LEVEL, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL idle_outputs: got {Valid,Dout,Last,Ready}=%b, required %b",
                         {Valid, Dout, Last, Ready}, {1'b0, IDLE_LEVEL, 1'b0, 1'b1});
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Queue the expected frame; exp_par is the hand-computed parity bit
    task automatic push_frame(input logic [7:0] p, input logic exp_par);
        for (int i = 0; i < WIDTH; i++) begin
            logic lst;
            lst = (i == WIDTH - 1) && !PAR;
            exp_q.push_back({p[WIDTH-1-i], lst, lst});
        end
        if (PAR) exp_q.push_back({exp_par, 1'b1, 1'b1});
    endtask

    // Called just after a posedge; returns just after the accepting edge
    task automatic send(input logic [7:0] p, input logic exp_par);
        Start   = 1'b1;
        Pattern = p;
        push_frame(p, exp_par);
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b1;
        Pattern = 8'hFF;

        // 1: reset held 3 cycles with Start high -> idle, no frame
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("reset_ready", int'(Ready), 1);
            check("reset_valid", int'(Valid), 0);
            check("reset_dout", int'(Dout), int'(IDLE_LEVEL));
        end
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge CLK);
        #1;
        check("post_reset_valid", int'(Valid), 0);

        // 2: single frame 8'hB2 (bits 1,0,1,1,0,0,1,0; parity 0)
        max_run = 0; last_cnt = 0;
        send(8'hB2, 1'b0);
        repeat (FL + 2) @(posedge CLK);
        #1;
        check("single_frame_len", max_run, FL);
        check("single_frame_lasts", last_cnt, 1);
        check("single_frame_drained", exp_q.size(), 0);

        // 3: back-to-back B2 then 0F started in the Last cycle
        max_run = 0; last_cnt = 0;
        send(8'hB2, 1'b0);
        repeat (FL - 1) @(posedge CLK);
        #1;
        check("b2b_ready_in_last", int'(Ready), 1);
        send(8'h0F, 1'b0);
        repeat (FL + 2) @(posedge CLK);
        #1;
        check("b2b_contiguous", max_run, 2 * FL);
        check("b2b_lasts", last_cnt, 2);
        check("b2b_drained", exp_q.size(), 0);

        // 4: Start pulsed mid-frame with 8'hFF is ignored; Pattern change has no effect
        max_run = 0; last_cnt = 0;
        send(8'hB2, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("busy_ready_low", int'(Ready), 0);
        Start   = 1'b1;
        Pattern = 8'hFF;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (FL + 2) @(posedge CLK);
        #1;
        check("ignored_start_len", max_run, FL);
        check("ignored_start_drained", exp_q.size(), 0);

        // 5: reset at the 4th bit of 8'hB2, then a clean 8'h81
        send(8'hB2, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        check("abort_valid", int'(Valid), 0);
        check("abort_ready", int'(Ready), 1);
        max_run = 0; last_cnt = 0;
        send(8'h81, 1'b0);
        repeat (FL + 2) @(posedge CLK);
        #1;
        check("after_abort_len", max_run, FL);
        check("after_abort_drained", exp_q.size(), 0);

        // 6: 8'h07 has odd weight (parity bit 1 when enabled)
        max_run = 0; last_cnt = 0;
        send(8'h07, 1'b1);
        repeat (FL + 2) @(posedge CLK);
        #1;
        check("p07_len", max_run, FL);
        check("p07_lasts", last_cnt, 1);
        check("p07_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
